// File: rtl/sasa_cam_array.sv
// sasa_cam_array: QK score CAM facing the SASA controller, with a registered search and a chunked subtract.
// Optional macro SASA_CAM_SAT_EN makes the subtract saturate at zero; without it the subtract wraps.
module sasa_cam_array #(
  parameter int CAM_LEN   = 16,
  parameter int DATA_W    = 8,
  parameter int IDX_W     = 4,
  parameter int SUB_LANES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               clear,
  input  logic               search_en,
  input  logic [DATA_W-1:0]  data4CAM,
  output logic [CAM_LEN-1:0] MatchVector,
  output logic               match_valid,
  input  logic               sub_en,
  input  logic [CAM_LEN-1:0] SUB_MatchVector,
  input  logic [DATA_W-1:0]  sub_val,
  output logic               busy,
  output logic               sub_done
);

  localparam int NUM_CHUNKS = CAM_LEN / SUB_LANES;
  localparam int CHUNK_W    = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

  state_t              state, state_next;
  logic [CHUNK_W-1:0]  chunk, chunk_next;
  logic [DATA_W-1:0]   entry [CAM_LEN];
  logic [CAM_LEN-1:0]  valid;
  logic [CAM_LEN-1:0]  cap_vec;
  logic [DATA_W-1:0]   cap_val;
  logic [CAM_LEN-1:0]  hit;
  logic                accept;

  // Commands are only honoured while idle; anything arriving mid-subtract is dropped.
  assign accept   = (state == IDLE);
  assign busy     = (state != IDLE);
  assign sub_done = (state == DONE);

  function automatic logic [DATA_W-1:0] sub_one(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
`ifdef SASA_CAM_SAT_EN
    return (a >= b) ? a - b : '0;
`else
    return a - b;
`endif
  endfunction

  always_comb begin
    hit = '0;
    for (int i = 0; i < CAM_LEN; i++) begin
      hit[i] = valid[i] && (entry[i] == data4CAM);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      chunk <= '0;
    end else begin
      state <= state_next;
      chunk <= chunk_next;
    end
  end

  always_comb begin
    state_next = state;
    chunk_next = chunk;
    case (state)
      IDLE: begin
        if (sub_en) begin
          state_next = SUB;
          chunk_next = '0;
        end
      end
      SUB: begin
        if (chunk == LAST_CHUNK) begin
          state_next = DONE;
          chunk_next = '0;
        end else begin
          chunk_next = chunk + CHUNK_W'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cap_vec <= '0;
      cap_val <= '0;
    end else if (accept && sub_en) begin
      cap_vec <= SUB_MatchVector;
      cap_val <= sub_val;
    end
  end

  // Search samples the pre-write contents; a write in the same cycle as clear survives the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid       <= '0;
      MatchVector <= '0;
      match_valid <= 1'b0;
    end else begin
      match_valid <= accept && search_en;
      if (accept && search_en) MatchVector <= hit;
      if (accept && clear) valid <= '0;
      if (accept && wr_en) valid[wr_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (accept && wr_en) begin
        entry[wr_addr] <= wr_data;
      end else if (state == SUB) begin
        for (int i = 0; i < CAM_LEN; i++) begin
          if ((int'(chunk) == i / SUB_LANES) && cap_vec[i] && valid[i]) begin
            entry[i] <= sub_one(entry[i], cap_val);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sasa_cam_array.sv
// tb_sasa_cam_array: directed scenarios plus random traffic against a CAM reference model.
// Search results go through a scoreboard queue drained by a negedge monitor.
`timescale 1ns/1ps
module tb_sasa_cam_array;

  localparam int CAM_LEN     = 16;
  localparam int DATA_W      = 8;
  localparam int IDX_W       = 4;
  localparam int SUB_LANES   = 4;
  localparam int BUSY_CYCLES = CAM_LEN / SUB_LANES + 1;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               wr_en = 1'b0;
  logic [IDX_W-1:0]   wr_addr = '0;
  logic [DATA_W-1:0]  wr_data = '0;
  logic               clear = 1'b0;
  logic               search_en = 1'b0;
  logic [DATA_W-1:0]  data4CAM = '0;
  logic [CAM_LEN-1:0] MatchVector;
  logic               match_valid;
  logic               sub_en = 1'b0;
  logic [CAM_LEN-1:0] SUB_MatchVector = '0;
  logic [DATA_W-1:0]  sub_val = '0;
  logic               busy;
  logic               sub_done;

  int checks = 0;
  int errors = 0;

  // Reference model: subtract is applied whole at acceptance, since nothing can observe it mid-way.
  logic [DATA_W-1:0]  model_entry [CAM_LEN];
  logic [CAM_LEN-1:0] model_valid = '0;
  logic [CAM_LEN-1:0] model_mv = '0;
  int                 busy_left = 0;
  logic [CAM_LEN-1:0] exp_q [$];

  sasa_cam_array #(
    .CAM_LEN(CAM_LEN), .DATA_W(DATA_W), .IDX_W(IDX_W), .SUB_LANES(SUB_LANES)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clear(clear),
    .search_en(search_en), .data4CAM(data4CAM),
    .MatchVector(MatchVector), .match_valid(match_valid),
    .sub_en(sub_en), .SUB_MatchVector(SUB_MatchVector), .sub_val(sub_val),
    .busy(busy), .sub_done(sub_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] modelSub(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    int r;
    r = int'(a) - int'(b);
`ifdef SASA_CAM_SAT_EN
    if (r < 0) r = 0;
`else
    if (r < 0) r = r + 256;
`endif
    return DATA_W'(r);
  endfunction

  function automatic logic [CAM_LEN-1:0] modelSearch(input logic [DATA_W-1:0] key);
    logic [CAM_LEN-1:0] r;
    r = '0;
    for (int i = 0; i < CAM_LEN; i++) begin
      if (model_valid[i] && model_entry[i] == key) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Drives one cycle of commands, advances the model at the edge, then checks status outputs.
  task automatic applyStimulus(input logic w, input logic [IDX_W-1:0] wa, input logic [DATA_W-1:0] wd,
                               input logic clr, input logic s, input logic [DATA_W-1:0] key,
                               input logic se, input logic [CAM_LEN-1:0] vec, input logic [DATA_W-1:0] val);
    logic [CAM_LEN-1:0] e;
    wr_en = w; wr_addr = wa; wr_data = wd; clear = clr;
    search_en = s; data4CAM = key;
    sub_en = se; SUB_MatchVector = vec; sub_val = val;
    @(posedge clk);
    if (busy_left == 0) begin
      if (s) begin
        e = modelSearch(key);
        exp_q.push_back(e);
        model_mv = e;
      end
      if (clr) model_valid = '0;
      if (w) begin
        model_entry[wa] = wd;
        model_valid[wa] = 1'b1;
      end
      if (se) begin
        for (int i = 0; i < CAM_LEN; i++) begin
          if (vec[i] && model_valid[i]) model_entry[i] = modelSub(model_entry[i], val);
        end
        busy_left = BUSY_CYCLES;
      end
    end else begin
      busy_left--;
    end
    #1;
    wr_en = 1'b0; clear = 1'b0; search_en = 1'b0; sub_en = 1'b0;
    SUB_MatchVector = $urandom(); sub_val = DATA_W'($urandom());
    checkOutput("busy", 32'(busy), 32'(busy_left != 0));
    checkOutput("sub_done", 32'(sub_done), 32'(busy_left == 1));
    checkOutput("match_vector_hold", 32'(MatchVector), 32'(model_mv));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, '0, '0, 0, 0, '0, 0, '0, '0);
  endtask

  task automatic doWrite(input int a, input int d);
    applyStimulus(1, IDX_W'(a), DATA_W'(d), 0, 0, '0, 0, '0, '0);
  endtask

  task automatic doSearch(input int key);
    applyStimulus(0, '0, '0, 0, 1, DATA_W'(key), 0, '0, '0);
  endtask

  task automatic doClear();
    applyStimulus(0, '0, '0, 1, 0, '0, 0, '0, '0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(posedge clk);
    model_valid = '0;
    model_mv = '0;
    busy_left = 0;
    #1;
    reset = 1'b0;
    checkOutput("reset_match_vector", 32'(MatchVector), 32'h0);
    checkOutput("reset_match_valid", 32'(match_valid), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_sub_done", 32'(sub_done), 32'h0);
  endtask

  // Every accepted search must show up exactly at the following negedge.
  always @(negedge clk) begin
    logic [CAM_LEN-1:0] e;
    if (match_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_match_valid", 32'h1, 32'h0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("scoreboard_match_vector", 32'(MatchVector), 32'(e));
      end
    end else if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checkOutput("missing_match_valid", 32'h0, 32'h1);
    end
  end

  initial begin
    int busy_cnt;
    int done_at;
    for (int i = 0; i < CAM_LEN; i++) model_entry[i] = '0;

    doReset();

    for (int i = 0; i < CAM_LEN; i++) doWrite(i, 10 * i);
    doSearch(50);
    checkOutput("tp_key50", 32'(MatchVector), 32'h0020);
    checkOutput("tp_key50_valid", 32'(match_valid), 32'h1);
    doSearch(7);
    checkOutput("tp_key7", 32'(MatchVector), 32'h0000);
    idle(1);
    checkOutput("tp_valid_pulse", 32'(match_valid), 32'h0);

    doWrite(3, 8'hC8);
    doWrite(9, 8'hC8);
    applyStimulus(1, 4'd9, 8'hC8, 1, 0, '0, 0, '0, '0);
    doSearch(8'hC8);
    checkOutput("tp_clear_write", 32'(MatchVector), 32'h0200);

    doClear();
    for (int i = 0; i < CAM_LEN; i++) doWrite(i, 100);
    applyStimulus(0, '0, '0, 0, 0, '0, 1, 16'h8001, 8'd30);
    busy_cnt = busy ? 1 : 0;
    done_at = 0;
    for (int k = 2; k <= 8; k++) begin
      applyStimulus(k == 3, 4'd5, 8'd70, 0, k == 3, 8'd100, 0, '0, '0);
      if (busy) busy_cnt++;
      if (sub_done) done_at = k;
    end
    checkOutput("tp_busy_length", 32'(busy_cnt), 32'd5);
    checkOutput("tp_sub_done_cycle", 32'(done_at), 32'd5);
    doSearch(70);
    checkOutput("tp_sub_hit", 32'(MatchVector), 32'h8001);
    doSearch(100);
    checkOutput("tp_sub_untouched", 32'(MatchVector), 32'h7FFE);

    doClear();
    doWrite(2, 5);
    applyStimulus(0, '0, '0, 0, 0, '0, 1, 16'h0004, 8'd20);
    idle(BUSY_CYCLES);
    doSearch(0);
`ifdef SASA_CAM_SAT_EN
    checkOutput("tp_underflow_sat", 32'(MatchVector[2]), 32'h1);
`endif
    doSearch(241);
`ifndef SASA_CAM_SAT_EN
    checkOutput("tp_underflow_wrap", 32'(MatchVector[2]), 32'h1);
`endif

    for (int i = 0; i < CAM_LEN; i++) doWrite(i, 100);
    applyStimulus(0, '0, '0, 0, 0, '0, 1, 16'hFFFF, 8'd1);
    idle(2);
    doReset();
    idle(BUSY_CYCLES + 1);
    doSearch(100);
    checkOutput("tp_reset_abort_100", 32'(MatchVector), 32'h0);
    doSearch(99);
    checkOutput("tp_reset_abort_99", 32'(MatchVector), 32'h0);

    doClear();
    applyStimulus(1, 4'd4, 8'd50, 0, 1, 8'd50, 1, 16'h0010, 8'd10);
    checkOutput("tp_same_cycle_prewrite", 32'(MatchVector[4]), 32'h0);
    idle(BUSY_CYCLES);
    doSearch(40);
    checkOutput("tp_same_cycle_sub", 32'(MatchVector), 32'h0010);

    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 99) < 40, IDX_W'($urandom_range(0, CAM_LEN - 1)),
                    DATA_W'($urandom_range(0, 31)), $urandom_range(0, 99) < 3,
                    $urandom_range(0, 99) < 50, DATA_W'($urandom_range(0, 31)),
                    $urandom_range(0, 99) < 8, CAM_LEN'($urandom()), DATA_W'($urandom_range(0, 40)));
    end

    idle(BUSY_CYCLES + 2);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
